fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//   Drain stage behind the 16x8 FIFO: pops one byte at a time through the FIFO's rd_en/data_out
//   handshake and sends it as an asynchronous serial frame on tx.
//   Frame: start(0), 8 data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
//   Never issues a pop while fifo_empty=1, so the FIFO's empty-read path is never exercised.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per serial bit (100 MHz / 115200); legal range >= 2
//   PARITY_EN     0    1 = insert a parity bit after bit 7
//   PARITY_ODD    0    0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
//   STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//   clk         in   1  clock; all state changes on posedge
//   rst         in   1  reset, synchronous, active-high
//   enable      in   1  1 = may start new frames; 0 = finish the current frame, then stay idle
//   fifo_empty  in   1  FIFO empty flag
//   fifo_data   in   8  FIFO data_out, valid the cycle after the rd_en edge
//   fifo_rd_en  out  1  one-cycle pop request to the FIFO (drive its rd_en)
//   tx          out  1  serial line; idles high
//   busy        out  1  1 from pop request to end of the last stop bit
//   tx_done     out  1  one-cycle pulse when the last stop bit completes
// BEHAVIOUR
//   Reset: tx=1, fifo_rd_en=0, busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0.
//   All outputs are registered.
//   States: IDLE -> POP -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   Edge k, in IDLE, enable=1 and fifo_empty=0: fifo_rd_en<=1, busy<=1, state<=POP.
//   Edge k+1 (POP): the FIFO samples rd_en and updates data_out; fifo_rd_en<=0, state<=LOAD.
//   Edge k+2 (LOAD): shift_reg<=fifo_data, tx<=0 (start bit), baud counter cleared, state<=START.
//   Bit timing: every bit holds exactly CLKS_PER_BIT cycles.
//   Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 at bit end.
//   DATA: tx=shift_reg[0]; shift right at each bit end; 8 bits tracked by a 3-bit index;
//   after index 7 go to PARITY if PARITY_EN, else STOP.
//   PARITY: tx = ^byte XOR PARITY_ODD, computed on the byte latched in LOAD.
//   STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end: tx_done=1 for one cycle,
//   busy<=0, state<=IDLE.
//   Frame length (tx low-going edge to tx_done) = (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
//   Back-to-back bytes: IDLE re-samples fifo_empty at the tx_done edge, so tx stays high for
//   2 extra cycles between frames (IDLE->POP->LOAD).
//   fifo_rd_en is never high for two consecutive cycles and never high when fifo_empty=1.
//   Writes into the FIFO during a frame are the FIFO's concern and do not affect this block.
//   enable falling mid-frame: the frame completes normally; no new pop follows.
//   enable falling in POP/LOAD: the byte is already popped and is transmitted.
//   rst mid-frame: next edge gives tx=1, busy=0, fifo_rd_en=0. The frame is lost.
//   No retransmission of the lost byte.
// STRUCTURE
//   Shared header uart_defs.vh: state localparams (IDLE, POP, LOAD, START, DATA, PARITY, STOP),
//   3-bit state width, default CLKS_PER_BIT.
//   Sub-module uart_baud_gen: parameterised bit-period counter; inputs clear; output bit_end
//   pulse on the last cycle of each bit. The top holds the FSM, shift register and handshake.
// TESTING (CLKS_PER_BIT=4 in simulation)
//   Reset: rst=1 for 3 cycles with fifo_empty=0 -> tx=1, busy=0, fifo_rd_en=0 throughout.
//   Single byte 0xA5, empty deasserted after the pop -> exactly one 1-cycle fifo_rd_en pulse.
//     tx: 0 x4, bits 1,0,1,0,0,1,0,1 x4 each, 1 x4; tx_done 40 cycles after tx falls.
//   fifo_empty=1 for 200 cycles, enable=1 -> fifo_rd_en never 1, tx constant 1, busy 0.
//   Back-to-back 0x00, 0xFF, 0x55 -> exactly 3 rd_en pulses, 3 correct frames,
//     tx high exactly 2 cycles between each tx_done and the next start bit.
//   PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0;
//     frame length 44 cycles.
//   rst during data bit 3 -> tx=1 next cycle, busy=0, no rd_en.
//     After release with empty=0, a fresh POP follows.
//   Separately: enable=0 during data bit 3 -> frame completes, no further pop.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter: FSM encoding,
// data width, default bit period and the parity helper.
package fifo_uart_tx_pkg;

  localparam int DATA_W               = 8;
  localparam int STATE_W              = 3;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  // Even parity of the byte, inverted when odd parity is selected.
  function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the 16x8 FIFO and its UART drain stage.
interface fifo_uart_tx_if;
  import fifo_uart_tx_pkg::*;

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;

  modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while clear is low and flags
// the last cycle of every bit on bit_end.
module fifo_uart_tx_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_r;

  // Bit-period counter, held at zero while the transmitter is not framing.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_r <= CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign bit_end = (cnt_r == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a FIFO: pops one byte through rd_en/data_out
// and serialises it as start, 8 data bits LSB first, optional parity, stop bits.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam logic PARITY_ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam logic STOP_LAST      = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  state_t            state_r;
  logic [DATA_W-1:0] shift_r;
  logic              parity_r;
  logic [2:0]        bit_idx_r;
  logic              stop_idx_r;
  logic              tx_r;
  logic              busy_r;
  logic              done_r;
  logic              rd_en_r;
  logic              baud_clear_s;
  logic              bit_end_s;

  // Baud counter only runs while a bit is on the line; LOAD clears it so
  // the start bit gets a full period.
  always_comb begin
    baud_clear_s = 1'b1;
    case (state_r)
      ST_START, ST_DATA, ST_PARITY, ST_STOP: baud_clear_s = 1'b0;
      default:                               baud_clear_s = 1'b1;
    endcase
  end

  fifo_uart_tx_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clear_s),
    .bit_end (bit_end_s)
  );

  // Frame sequencer, shift register and FIFO pop handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      shift_r    <= 8'h00;
      parity_r   <= 1'b0;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_en_r    <= 1'b0;
    end else begin
      rd_en_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (enable && !fifo.fifo_empty) begin
            rd_en_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_POP;
          end
        end
        ST_POP: begin
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          shift_r    <= fifo.fifo_data;
          parity_r   <= calc_parity(fifo.fifo_data, PARITY_ODD_BIT);
          bit_idx_r  <= 3'd0;
          stop_idx_r <= 1'b0;
          tx_r       <= 1'b0;
          state_r    <= ST_START;
        end
        ST_START: begin
          if (bit_end_s) begin
            tx_r    <= shift_r[0];
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            if (bit_idx_r == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx_r    <= parity_r;
                state_r <= ST_PARITY;
              end else begin
                tx_r    <= 1'b1;
                state_r <= ST_STOP;
              end
            end else begin
              shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
              tx_r      <= shift_r[1];
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end_s) begin
            tx_r    <= 1'b1;
            state_r <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            if (stop_idx_r == STOP_LAST) begin
              done_r <= 1'b1;
              // Re-sample the FIFO on the done edge so back-to-back frames
              // are separated by only the POP and LOAD cycles.
              if (enable && !fifo.fifo_empty) begin
                rd_en_r <= 1'b1;
                state_r <= ST_POP;
              end else begin
                busy_r  <= 1'b0;
                state_r <= ST_IDLE;
              end
            end else begin
              stop_idx_r <= stop_idx_r + 1'b1;
            end
          end
        end
        default: begin
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx              = tx_r;
  assign busy            = busy_r;
  assign tx_done         = done_r;
  assign fifo.fifo_rd_en = rd_en_r;

endmodule
